alu_reservation_station: RTL and testbench

- Multi-entry ALU reservation station. Replaces per-entry latch-based ALURStationEntry instances with one fully synchronous, parametrised array.
- Accepts one dispatched instruction per cycle from decode/rename and snoops the common data bus (CDB) for missing operands.
- Selects one ready instruction per cycle and issues it to the ALU through a valid/ready handshake.
- Flushes wholesale on pipeline clear (mispredict/exception).

---
 rtl/alu_reservation_station_if.sv | 48 ++++
 rtl/alu_reservation_station.sv | 164 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
// The station itself binds to the slave modport; the upstream/downstream side binds to master.
interface alu_reservation_station_if #(
  parameter int WIDTH  = 32,
  parameter int ROB_W  = 3,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic              dispValid;
  logic              dispReady;
  logic [CTRL_W-1:0] dispCtrl;
  logic [ROB_W-1:0]  dispRob;
  logic [WIDTH-1:0]  dispVal1;
  logic [WIDTH-1:0]  dispVal2;
  logic              dispRdy1;
  logic              dispRdy2;
  logic [ROB_W-1:0]  dispTag1;
  logic [ROB_W-1:0]  dispTag2;
  logic              cdbValid;
  logic [ROB_W-1:0]  cdbRob;
  logic [WIDTH-1:0]  cdbResult;
  logic              issueValid;
  logic              issueReady;
  logic [CTRL_W-1:0] issueCtrl;
  logic [ROB_W-1:0]  issueRob;
  logic [WIDTH-1:0]  issueSrc1;
  logic [WIDTH-1:0]  issueSrc2;
  logic [IDX_W:0]    freeCount;
  logic              full;
  logic              flush;

  modport slave (
    input  flush, dispValid, dispCtrl, dispRob, dispVal1, dispVal2,
           dispRdy1, dispRdy2, dispTag1, dispTag2,
           cdbValid, cdbRob, cdbResult, issueReady,
    output dispReady, issueValid, issueCtrl, issueRob, issueSrc1, issueSrc2,
           freeCount, full
  );

  modport master (
    output flush, dispValid, dispCtrl, dispRob, dispVal1, dispVal2,
           dispRdy1, dispRdy2, dispTag1, dispTag2,
           cdbValid, cdbRob, cdbResult, issueReady,
    input  dispReady, issueValid, issueCtrl, issueRob, issueSrc1, issueSrc2,
           freeCount, full
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Flop-based multi-entry ALU reservation station with CDB wakeup and valid/ready issue.
// Define RS_AGE_SELECT_EN to issue oldest-eligible instead of lowest-index-eligible.
module alu_reservation_station #(
  parameter int WIDTH  = 32,
  parameter int ROB_W  = 3,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input logic                        clk,
  input logic                        reset_n,
  alu_reservation_station_if.slave   rs
);

  logic [DEPTH-1:0]  busy, rdy1, rdy2;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [WIDTH-1:0]  val1_q [DEPTH];
  logic [WIDTH-1:0]  val2_q [DEPTH];
  logic [ROB_W-1:0]  tag1_q [DEPTH];
  logic [ROB_W-1:0]  tag2_q [DEPTH];
  logic [IDX_W:0]    free_cnt;
  logic              lock;
  logic [IDX_W-1:0]  lock_idx;
`ifdef RS_AGE_SELECT_EN
  logic [DEPTH-1:0]  age [DEPTH];
`endif

  logic [DEPTH-1:0]  elig, busy_nxt;
  logic [IDX_W-1:0]  wr_idx, sel_idx;
  logic              disp_en, issue_fire;

  function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction

  assign rs.full      = (free_cnt == '0);
  assign rs.dispReady = (free_cnt != '0);
  assign rs.freeCount = free_cnt;
  assign disp_en      = rs.dispValid & rs.dispReady;
  assign elig         = busy & rdy1 & rdy2;
  assign rs.issueValid = |elig;
  assign issue_fire   = rs.issueValid & rs.issueReady;

  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy[i]) wr_idx = IDX_W'(i);
  end

  // Selection is held while the ALU back-pressures so the presented instruction cannot change.
  always_comb begin
    sel_idx = '0;
`ifdef RS_AGE_SELECT_EN
    for (int i = 0; i < DEPTH; i++) begin
      logic [DEPTH-1:0] older;
      for (int j = 0; j < DEPTH; j++) older[j] = age[j][i];
      if (elig[i] && ((elig & older) == '0)) sel_idx = IDX_W'(i);
    end
`else
    for (int i = DEPTH-1; i >= 0; i--)
      if (elig[i]) sel_idx = IDX_W'(i);
`endif
    if (lock) sel_idx = lock_idx;
  end

  assign rs.issueCtrl = ctrl_q[sel_idx];
  assign rs.issueRob  = rob_q[sel_idx];
  assign rs.issueSrc1 = val1_q[sel_idx];
  assign rs.issueSrc2 = val2_q[sel_idx];

  always_comb begin
    busy_nxt = busy;
    if (issue_fire) busy_nxt[sel_idx] = 1'b0;
    if (disp_en)    busy_nxt[wr_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      rdy1     <= '0;
      rdy2     <= '0;
      free_cnt <= (IDX_W+1)'(DEPTH);
      lock     <= 1'b0;
      lock_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        rob_q[i]  <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
        age[i]    <= '0;
`endif
      end
    end else if (rs.flush) begin
      busy     <= '0;
      rdy1     <= '0;
      rdy2     <= '0;
      free_cnt <= (IDX_W+1)'(DEPTH);
      lock     <= 1'b0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && rs.cdbValid) begin
          if (!rdy1[i] && tag1_q[i] == rs.cdbRob) begin
            val1_q[i] <= rs.cdbResult;
            rdy1[i]   <= 1'b1;
          end
          if (!rdy2[i] && tag2_q[i] == rs.cdbRob) begin
            val2_q[i] <= rs.cdbResult;
            rdy2[i]   <= 1'b1;
          end
        end
      end

      // Dispatch targets a non-busy slot, so it never collides with wakeup or issue above.
      if (disp_en) begin
        ctrl_q[wr_idx] <= rs.dispCtrl;
        rob_q[wr_idx]  <= rs.dispRob;
        tag1_q[wr_idx] <= rs.dispTag1;
        tag2_q[wr_idx] <= rs.dispTag2;
        if (rs.dispRdy1) begin
          val1_q[wr_idx] <= rs.dispVal1;
          rdy1[wr_idx]   <= 1'b1;
        end else if (rs.cdbValid && rs.cdbRob == rs.dispTag1) begin
          val1_q[wr_idx] <= rs.cdbResult;
          rdy1[wr_idx]   <= 1'b1;
        end else begin
          val1_q[wr_idx] <= rs.dispVal1;
          rdy1[wr_idx]   <= 1'b0;
        end
        if (rs.dispRdy2) begin
          val2_q[wr_idx] <= rs.dispVal2;
          rdy2[wr_idx]   <= 1'b1;
        end else if (rs.cdbValid && rs.cdbRob == rs.dispTag2) begin
          val2_q[wr_idx] <= rs.cdbResult;
          rdy2[wr_idx]   <= 1'b1;
        end else begin
          val2_q[wr_idx] <= rs.dispVal2;
          rdy2[wr_idx]   <= 1'b0;
        end
`ifdef RS_AGE_SELECT_EN
        for (int j = 0; j < DEPTH; j++) begin
          age[wr_idx][j] <= 1'b0;
          age[j][wr_idx] <= busy[j];
        end
`endif
      end

      busy     <= busy_nxt;
      free_cnt <= (IDX_W+1)'(DEPTH) - popcount(busy_nxt);
      lock     <= rs.issueValid & ~rs.issueReady;
      lock_idx <= sel_idx;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: expected issues are queued by the stimulus
// and consumed by a monitor on every accepted issue handshake.
module tb_alu_reservation_station;
  localparam int WIDTH = 32, ROB_W = 3, CTRL_W = 4, DEPTH = 4, IDX_W = 2;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [ROB_W-1:0]  rob;
    logic [WIDTH-1:0]  s1;
    logic [WIDTH-1:0]  s2;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_reservation_station_if #(.WIDTH(WIDTH), .ROB_W(ROB_W), .CTRL_W(CTRL_W),
                               .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  alu_reservation_station #(.WIDTH(WIDTH), .ROB_W(ROB_W), .CTRL_W(CTRL_W),
                            .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rs      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [3:0] ctrl, input logic [2:0] rob,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic r1, input logic r2,
                          input logic [2:0] t1, input logic [2:0] t2);
    bus.dispValid = 1'b1;
    bus.dispCtrl  = ctrl;
    bus.dispRob   = rob;
    bus.dispVal1  = v1;
    bus.dispVal2  = v2;
    bus.dispRdy1  = r1;
    bus.dispRdy2  = r2;
    bus.dispTag1  = t1;
    bus.dispTag2  = t2;
  endtask

  task automatic push(input logic [3:0] ctrl, input logic [2:0] rob,
                      input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    e.ctrl = ctrl; e.rob = rob; e.s1 = s1; e.s2 = s2;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted issue must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && bus.issueValid && bus.issueReady) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got rob %0d with nothing expected", bus.issueRob);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_ctrl", 32'(bus.issueCtrl), 32'(e.ctrl));
        chk("issue_rob",  32'(bus.issueRob),  32'(e.rob));
        chk("issue_src1", bus.issueSrc1, e.s1);
        chk("issue_src2", bus.issueSrc2, e.s2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tags [4];
    tags[0] = 3'd4; tags[1] = 3'd0; tags[2] = 3'd6; tags[3] = 3'd7;

    bus.flush = 0; bus.dispValid = 0; bus.dispCtrl = 0; bus.dispRob = 0;
    bus.dispVal1 = 0; bus.dispVal2 = 0; bus.dispRdy1 = 0; bus.dispRdy2 = 0;
    bus.dispTag1 = 0; bus.dispTag2 = 0; bus.cdbValid = 0; bus.cdbRob = 0;
    bus.cdbResult = 0; bus.issueReady = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_issueValid", 32'(bus.issueValid), 0);
    chk("rst_dispReady",  32'(bus.dispReady), 1);
    chk("rst_full",       32'(bus.full), 0);
    chk("rst_freeCount",  32'(bus.freeCount), DEPTH);
    chk("rst_issueCtrl",  32'(bus.issueCtrl), 0);
    chk("rst_issueRob",   32'(bus.issueRob), 0);
    chk("rst_issueSrc1",  bus.issueSrc1, 0);
    chk("rst_issueSrc2",  bus.issueSrc2, 0);

    // Ready-at-dispatch instruction
    set_disp(4'd3, 3'd5, 32'd10, 32'd20, 1, 1, 0, 0);
    tick();
    bus.dispValid = 0;
    chk("t1_issueValid", 32'(bus.issueValid), 1);
    chk("t1_issueRob",   32'(bus.issueRob), 5);
    chk("t1_issueSrc1",  bus.issueSrc1, 10);
    chk("t1_issueSrc2",  bus.issueSrc2, 20);
    chk("t1_freeCount",  32'(bus.freeCount), DEPTH-1);
    push(4'd3, 3'd5, 32'd10, 32'd20);
    bus.issueReady = 1;
    tick();
    bus.issueReady = 0;
    chk("t1_freeAfter",  32'(bus.freeCount), DEPTH);
    chk("t1_idleAfter",  32'(bus.issueValid), 0);

    // CDB wakeup, non-matching broadcast ignored
    set_disp(4'd1, 3'd2, 32'd0, 32'd7, 0, 1, 3'd6, 0);
    tick();
    bus.dispValid = 0;
    chk("t2_notReady", 32'(bus.issueValid), 0);
    bus.cdbValid = 1; bus.cdbRob = 3'd7; bus.cdbResult = 32'h1234;
    tick();
    chk("t2_noCapture", 32'(bus.issueValid), 0);
    bus.cdbRob = 3'd6; bus.cdbResult = 32'hDEAD;
    #1;
    chk("t2_noCombPath", 32'(bus.issueValid), 0);
    tick();
    bus.cdbValid = 0;
    chk("t2_woken",    32'(bus.issueValid), 1);
    chk("t2_src1",     bus.issueSrc1, 32'hDEAD);
    push(4'd1, 3'd2, 32'hDEAD, 32'd7);
    bus.issueReady = 1;
    tick();
    bus.issueReady = 0;

    // Same-cycle dispatch/CDB bypass
    bus.cdbValid = 1; bus.cdbRob = 3'd4; bus.cdbResult = 32'd99;
    set_disp(4'd2, 3'd3, 32'd0, 32'd5, 0, 1, 3'd4, 0);
    tick();
    bus.dispValid = 0; bus.cdbValid = 0;
    chk("t3_bypassValid", 32'(bus.issueValid), 1);
    chk("t3_bypassSrc1",  bus.issueSrc1, 32'd99);
    push(4'd2, 3'd3, 32'd99, 32'd5);
    bus.issueReady = 1;
    tick();
    bus.issueReady = 0;

    // Fill, drop when full, issue+dispatch in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(4'(8+i), 3'(i), 32'd0, 32'(100+i), 0, 1, tags[i], 0);
      tick();
    end
    bus.dispValid = 0;
    chk("t4_full",      32'(bus.full), 1);
    chk("t4_dispReady", 32'(bus.dispReady), 0);
    chk("t4_freeZero",  32'(bus.freeCount), 0);
    chk("t4_noneReady", 32'(bus.issueValid), 0);
    set_disp(4'd15, 3'd7, 32'd70, 32'd71, 1, 1, 0, 0);
    tick();
    bus.dispValid = 0;
    chk("t4_dropped",   32'(bus.freeCount), 0);
    chk("t4_dropIdle",  32'(bus.issueValid), 0);
    bus.cdbValid = 1; bus.cdbRob = 3'd6; bus.cdbResult = 32'h66;
    tick();
    bus.cdbValid = 0;
    chk("t4_e2Valid", 32'(bus.issueValid), 1);
    chk("t4_e2Rob",   32'(bus.issueRob), 2);
    push(4'd10, 3'd2, 32'h66, 32'd102);
    bus.issueReady = 1;
    set_disp(4'd15, 3'd7, 32'd70, 32'd71, 1, 1, 0, 0);
    #1;
    chk("t4_refuseReady", 32'(bus.dispReady), 0);
    tick();
    bus.issueReady = 0;
    chk("t4_refusedFree", 32'(bus.freeCount), 1);
    chk("t4_readyAgain",  32'(bus.dispReady), 1);
    chk("t4_noIssue",     32'(bus.issueValid), 0);
    tick();
    bus.dispValid = 0;
    chk("t4_acceptFree",  32'(bus.freeCount), 0);
    chk("t4_newRob",      32'(bus.issueRob), 7);
    push(4'd15, 3'd7, 32'd70, 32'd71);
    bus.issueReady = 1;
    tick();
    bus.issueReady = 0;
    chk("t4_freeOne",     32'(bus.freeCount), 1);

    // Back-pressure stability with a lower entry waking meanwhile, then flush
    bus.cdbValid = 1; bus.cdbRob = 3'd7; bus.cdbResult = 32'h77;
    tick();
    bus.cdbValid = 0;
    chk("t5_e3Rob", 32'(bus.issueRob), 3);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        bus.cdbValid = 1; bus.cdbRob = 3'd0; bus.cdbResult = 32'h11;
      end else begin
        bus.cdbValid = 0;
      end
      tick();
      chk("t5_holdValid", 32'(bus.issueValid), 1);
      chk("t5_holdRob",   32'(bus.issueRob), 3);
      chk("t5_holdSrc1",  bus.issueSrc1, 32'h77);
    end
    bus.cdbValid = 0;
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("t5_flushValid", 32'(bus.issueValid), 0);
    chk("t5_flushFree",  32'(bus.freeCount), DEPTH);
    chk("t5_flushFull",  32'(bus.full), 0);

    // Asynchronous reset mid-cycle
    set_disp(4'd5, 3'd5, 32'd1, 32'd2, 1, 1, 0, 0);
    tick();
    bus.dispValid = 0;
    chk("t5_preRstFree", 32'(bus.freeCount), DEPTH-1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_asyncFree",  32'(bus.freeCount), DEPTH);
    chk("t5_asyncValid", 32'(bus.issueValid), 0);
    #1 reset_n = 1'b1;
    tick();

    // Two entries woken by one broadcast: rob 1 (entry 0, oldest) before rob 3 (entry 2)
    set_disp(4'd4, 3'd1, 32'd0, 32'h10, 0, 1, 3'd6, 0); tick();
    set_disp(4'd4, 3'd2, 32'd0, 32'h20, 0, 1, 3'd5, 0); tick();
    set_disp(4'd4, 3'd3, 32'd0, 32'h30, 0, 1, 3'd6, 0); tick();
    bus.dispValid = 0;
    chk("t6_noneReady", 32'(bus.issueValid), 0);
    bus.cdbValid = 1; bus.cdbRob = 3'd6; bus.cdbResult = 32'hAB;
    tick();
    bus.cdbValid = 0;
    chk("t6_firstRob", 32'(bus.issueRob), 1);
    push(4'd4, 3'd1, 32'hAB, 32'h10);
    push(4'd4, 3'd3, 32'hAB, 32'h30);
    bus.issueReady = 1;
    tick();
    chk("t6_secondRob", 32'(bus.issueRob), 3);
    tick();
    bus.issueReady = 0;
    chk("t6_drained", 32'(bus.issueValid), 0);
    chk("t6_free",    32'(bus.freeCount), DEPTH-1);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    tick();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
